// File: rtl/key_req_if.sv
// Client-side command/response handshake bundle for key_req_master.
// The slave modport is the controller's view; master is the client's view.
`timescale 1ns/1ps
interface key_req_if #(
   parameter int KEY_WIDTH   = 32,
   parameter int INDEX_WIDTH = 8
);
   logic                     cmd_valid;
   logic                     cmd_ready;
   logic                     cmd_write;
   logic [1:0]               cmd_lane_en;
   logic [2*INDEX_WIDTH-1:0] cmd_addr;
   logic [2*KEY_WIDTH-1:0]   cmd_key;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [2*KEY_WIDTH-1:0]   rsp_key;
   logic [1:0]               rsp_lane;

   modport master (
      output cmd_valid, cmd_write, cmd_lane_en, cmd_addr, cmd_key, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_key, rsp_lane
   );

   modport slave (
      input  cmd_valid, cmd_write, cmd_lane_en, cmd_addr, cmd_key, rsp_ready,
      output cmd_ready, rsp_valid, rsp_key, rsp_lane
   );
endinterface

// File: rtl/key_req_master.sv
// Initiator-side controller for the dual-lane key register file with a credited response FIFO.
// Optional KEY_REQ_STATS_EN adds saturating write/read command counters.
`timescale 1ns/1ps
module key_req_master #(
   parameter int KEY_WIDTH   = 32,
   parameter int INDEX_WIDTH = 8,
   parameter int RESP_DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   key_req_if.slave                 bus,
   output logic [1:0]               rf_w_en,
   output logic [2*INDEX_WIDTH-1:0] rf_w_addr,
   output logic [2*KEY_WIDTH-1:0]   rf_key_write,
   output logic [1:0]               rf_r_en,
   output logic [2*INDEX_WIDTH-1:0] rf_r_addr,
   input  logic [2*KEY_WIDTH-1:0]   rf_key_read,
   output logic [7:0]               conflict_cnt
`ifdef KEY_REQ_STATS_EN
   ,
   output logic [15:0]              wr_cmd_cnt,
   output logic [15:0]              rd_cmd_cnt
`endif
);
   localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic                     cmd_ready_r;
   logic [1:0]               rf_w_en_r;
   logic [2*INDEX_WIDTH-1:0] rf_w_addr_r;
   logic [2*KEY_WIDTH-1:0]   rf_key_write_r;
   logic [1:0]               rf_r_en_r;
   logic [2*INDEX_WIDTH-1:0] rf_r_addr_r;
   logic [7:0]               conflict_cnt_r;
   logic [1:0]               cap_lane_r;

   logic [2*KEY_WIDTH-1:0]   key_mem_r  [RESP_DEPTH];
   logic [1:0]               lane_mem_r [RESP_DEPTH];
   logic [PTR_W-1:0]         wr_ptr_r;
   logic [PTR_W-1:0]         rd_ptr_r;
   logic [CNT_W-1:0]         cnt_r;

   logic                     accept_s;
   logic                     wr_acc_s;
   logic                     rd_acc_s;
   logic                     same_addr_s;
   logic                     conflict_s;
   logic [1:0]               w_en_s;
   logic [1:0]               r_en_s;
   logic                     iss_valid_s;
   logic                     push_s;
   logic                     pop_s;
   logic [CNT_W-1:0]         cnt_next_s;
   logic [CNT_W:0]           credit_s;
   logic                     ready_next_s;
   logic [2*KEY_WIDTH-1:0]   push_key_s;

   // Command decode, lane masking and next-cycle credit.
   always_comb begin
      accept_s    = bus.cmd_valid & cmd_ready_r;
      wr_acc_s    = accept_s & (bus.cmd_lane_en != 2'b00) & bus.cmd_write;
      rd_acc_s    = accept_s & (bus.cmd_lane_en != 2'b00) & ~bus.cmd_write;
      same_addr_s = (bus.cmd_addr[INDEX_WIDTH-1:0] == bus.cmd_addr[2*INDEX_WIDTH-1:INDEX_WIDTH]);
      conflict_s  = wr_acc_s & (bus.cmd_lane_en == 2'b11) & same_addr_s;
      // Lane 1 wins a same-address dual write, so lane 0 is dropped.
      w_en_s      = wr_acc_s ? {bus.cmd_lane_en[1], bus.cmd_lane_en[0] & ~conflict_s} : 2'b00;
      r_en_s      = rd_acc_s ? bus.cmd_lane_en : 2'b00;
      iss_valid_s = (rf_r_en_r != 2'b00);
      push_s      = (cap_lane_r != 2'b00);
      pop_s       = (cnt_r != {CNT_W{1'b0}}) & bus.rsp_ready;
      cnt_next_s  = cnt_r + CNT_W'(push_s) - CNT_W'(pop_s);
      // A pop this cycle is deliberately not credited until next cycle.
      credit_s    = {1'b0, cnt_r} + (CNT_W+1)'(push_s) + (CNT_W+1)'(iss_valid_s)
                    + (CNT_W+1)'(rd_acc_s);
      ready_next_s = (credit_s < (CNT_W+1)'(RESP_DEPTH));
      push_key_s  = {(2*KEY_WIDTH){1'b0}};
      for (int i = 0; i < 2; i++) begin
         if (cap_lane_r[i]) begin
            push_key_s[i*KEY_WIDTH +: KEY_WIDTH] = rf_key_read[i*KEY_WIDTH +: KEY_WIDTH];
         end else begin
            push_key_s[i*KEY_WIDTH +: KEY_WIDTH] = {KEY_WIDTH{1'b0}};
         end
      end
   end

   // Issue stage, capture stage tracking, credit register and conflict counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_ready_r    <= 1'b0;
         rf_w_en_r      <= 2'b00;
         rf_w_addr_r    <= {(2*INDEX_WIDTH){1'b0}};
         rf_key_write_r <= {(2*KEY_WIDTH){1'b0}};
         rf_r_en_r      <= 2'b00;
         rf_r_addr_r    <= {(2*INDEX_WIDTH){1'b0}};
         cap_lane_r     <= 2'b00;
         conflict_cnt_r <= 8'd0;
      end else begin
         cmd_ready_r <= ready_next_s;
         rf_w_en_r   <= w_en_s;
         rf_r_en_r   <= r_en_s;
         cap_lane_r  <= rf_r_en_r;
         if (wr_acc_s) begin
            rf_w_addr_r    <= bus.cmd_addr;
            rf_key_write_r <= bus.cmd_key;
         end
         if (rd_acc_s) begin
            rf_r_addr_r <= bus.cmd_addr;
         end
         if (conflict_s && (conflict_cnt_r != 8'hFF)) begin
            conflict_cnt_r <= conflict_cnt_r + 8'd1;
         end
      end
   end

   // Response FIFO storage and pointers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         cnt_r    <= {CNT_W{1'b0}};
         for (int i = 0; i < RESP_DEPTH; i++) begin
            key_mem_r[i]  <= {(2*KEY_WIDTH){1'b0}};
            lane_mem_r[i] <= 2'b00;
         end
      end else begin
         if (push_s) begin
            key_mem_r[wr_ptr_r]  <= push_key_s;
            lane_mem_r[wr_ptr_r] <= cap_lane_r;
            wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         cnt_r <= cnt_next_s;
      end
   end

   assign bus.cmd_ready = cmd_ready_r;
   assign bus.rsp_valid = (cnt_r != {CNT_W{1'b0}});
   assign bus.rsp_key   = key_mem_r[rd_ptr_r];
   assign bus.rsp_lane  = lane_mem_r[rd_ptr_r];
   assign rf_w_en       = rf_w_en_r;
   assign rf_w_addr     = rf_w_addr_r;
   assign rf_key_write  = rf_key_write_r;
   assign rf_r_en       = rf_r_en_r;
   assign rf_r_addr     = rf_r_addr_r;
   assign conflict_cnt  = conflict_cnt_r;

`ifdef KEY_REQ_STATS_EN
   logic [15:0] wr_cmd_cnt_r;
   logic [15:0] rd_cmd_cnt_r;

   // Saturating counts of accepted commands that enable at least one lane.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_cmd_cnt_r <= 16'd0;
         rd_cmd_cnt_r <= 16'd0;
      end else begin
         if (wr_acc_s && (wr_cmd_cnt_r != 16'hFFFF)) begin
            wr_cmd_cnt_r <= wr_cmd_cnt_r + 16'd1;
         end
         if (rd_acc_s && (rd_cmd_cnt_r != 16'hFFFF)) begin
            rd_cmd_cnt_r <= rd_cmd_cnt_r + 16'd1;
         end
      end
   end

   assign wr_cmd_cnt = wr_cmd_cnt_r;
   assign rd_cmd_cnt = rd_cmd_cnt_r;
`endif
endmodule

// File: tb/tb_key_req_master.sv
// Scoreboard bench for key_req_master: directed commands push expected responses,
// a negedge monitor pops and compares whatever the DUT hands back.
`timescale 1ns/1ps
module tb_key_req_master;
   logic        clk;
   logic        reset;
   logic [1:0]  rf_w_en;
   logic [15:0] rf_w_addr;
   logic [63:0] rf_key_write;
   logic [1:0]  rf_r_en;
   logic [15:0] rf_r_addr;
   logic [63:0] rf_key_read;
   logic [7:0]  conflict_cnt;
`ifdef KEY_REQ_STATS_EN
   logic [15:0] wr_cmd_cnt;
   logic [15:0] rd_cmd_cnt;
`endif

   key_req_if #(.KEY_WIDTH(32), .INDEX_WIDTH(8)) bus ();

   key_req_master #(.KEY_WIDTH(32), .INDEX_WIDTH(8), .RESP_DEPTH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .rf_w_en      (rf_w_en),
      .rf_w_addr    (rf_w_addr),
      .rf_key_write (rf_key_write),
      .rf_r_en      (rf_r_en),
      .rf_r_addr    (rf_r_addr),
      .rf_key_read  (rf_key_read),
      .conflict_cnt (conflict_cnt)
`ifdef KEY_REQ_STATS_EN
      ,
      .wr_cmd_cnt   (wr_cmd_cnt),
      .rd_cmd_cnt   (rd_cmd_cnt)
`endif
   );

   typedef struct {
      logic [63:0] key;
      logic [1:0]  lane;
   } rsp_t;

   rsp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   acc_cnt  = 0;
   logic [31:0] rf_mem [0:255];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared-storage register file: two write ports, two read ports, 1-cycle read.
   always @(posedge clk) begin
      if (rf_w_en[0]) rf_mem[rf_w_addr[7:0]] <= rf_key_write[31:0];
      if (rf_w_en[1]) rf_mem[rf_w_addr[15:8]] <= rf_key_write[63:32];
      if (rf_r_en[0]) rf_key_read[31:0] <= rf_mem[rf_r_addr[7:0]];
      if (rf_r_en[1]) rf_key_read[63:32] <= rf_mem[rf_r_addr[15:8]];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one command, wait (bounded) for acceptance, queue the expected response.
   task automatic send(input logic wr, input logic [1:0] lane, input logic [15:0] addr,
                       input logic [63:0] key, input logic [63:0] exp_key);
      logic ok;
      rsp_t r;
      ok = 1'b0;
      bus.cmd_valid   = 1'b1;
      bus.cmd_write   = wr;
      bus.cmd_lane_en = lane;
      bus.cmd_addr    = addr;
      bus.cmd_key     = key;
      for (int i = 0; i < 200 && !ok; i++) begin
         ok = bus.cmd_ready;
         tick();
      end
      bus.cmd_valid = 1'b0;
      check("cmd_accept", {63'd0, ok}, 64'd1);
      if (ok) begin
         acc_cnt++;
         if (!wr && lane != 2'b00) begin
            r.key  = exp_key;
            r.lane = lane;
            exp_q.push_back(r);
         end
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
      check("drain", 64'(exp_q.size()), 64'd0);
   endtask

   // Monitor: a handshake seen at negedge completes at the following posedge.
   always @(negedge clk) begin
      if (!reset && bus.rsp_valid && bus.rsp_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rsp", {63'd0, bus.rsp_valid}, 64'd0);
         end else begin
            rsp_t e;
            e = exp_q.pop_front();
            check("rsp_key", bus.rsp_key, e.key);
            check("rsp_lane", {62'd0, bus.rsp_lane}, {62'd0, e.lane});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset           = 1'b1;
      bus.cmd_valid   = 1'b0;
      bus.cmd_write   = 1'b0;
      bus.cmd_lane_en = 2'b00;
      bus.cmd_addr    = 16'd0;
      bus.cmd_key     = 64'd0;
      bus.rsp_ready   = 1'b1;
      repeat (3) tick();
      check("rst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd0);
      check("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
      check("rst_rf_en", {60'd0, rf_w_en, rf_r_en}, 64'd0);
      check("rst_conflict", {56'd0, conflict_cnt}, 64'd0);
      reset = 1'b0;
      tick();
      check("ready_after_rst", {63'd0, bus.cmd_ready}, 64'd1);

      // 1: write then read lane 0, checking issue timing and latency
      send(1'b1, 2'b01, 16'h0005, 64'h0000_0000_A5A5_A5A5, 64'd0);
      check("t1_w_en", {62'd0, rf_w_en}, 64'd1);
      check("t1_w_addr", {48'd0, rf_w_addr}, 64'h0005);
      check("t1_w_key", {32'd0, rf_key_write[31:0]}, 64'hA5A5_A5A5);
      send(1'b0, 2'b01, 16'h0005, 64'd0, 64'h0000_0000_A5A5_A5A5);
      check("t1_w_en_drop", {62'd0, rf_w_en}, 64'd0);
      check("t1_r_en", {62'd0, rf_r_en}, 64'd1);
      check("t1_rsp_early", {63'd0, bus.rsp_valid}, 64'd0);
      tick();
      check("t1_r_en_drop", {62'd0, rf_r_en}, 64'd0);
      check("t1_rsp_early2", {63'd0, bus.rsp_valid}, 64'd0);
      tick();
      check("t1_rsp_latency", {63'd0, bus.rsp_valid}, 64'd1);
      wait_drain();

      // 2: dual-lane write to 3/7 then dual read
      send(1'b1, 2'b11, {8'd7, 8'd3}, 64'h2222_2222_1111_1111, 64'd0);
      check("t2_w_en", {62'd0, rf_w_en}, 64'd3);
      send(1'b0, 2'b11, {8'd7, 8'd3}, 64'd0, 64'h2222_2222_1111_1111);
      wait_drain();

      // 3: back-pressure with 6 back-to-back reads
      for (int i = 0; i < 6; i++)
         send(1'b1, 2'b01, {8'd0, 8'(20 + i)}, {32'd0, 32'hC0DE_0000 + 32'(i)}, 64'd0);
      bus.rsp_ready = 1'b0;
      acc_cnt = 0;
      fork
         begin
            for (int i = 0; i < 6; i++)
               send(1'b0, 2'b01, {8'd0, 8'(20 + i)}, 64'd0, {32'd0, 32'hC0DE_0000 + 32'(i)});
         end
         begin
            repeat (10) tick();
            check("t3_accepted", 64'(acc_cnt), 64'd4);
            check("t3_ready_low", {63'd0, bus.cmd_ready}, 64'd0);
            check("t3_head_key", bus.rsp_key, 64'h0000_0000_C0DE_0000);
            repeat (4) tick();
            check("t3_valid_held", {63'd0, bus.rsp_valid}, 64'd1);
            check("t3_key_stable", bus.rsp_key, 64'h0000_0000_C0DE_0000);
            check("t3_lane_stable", {62'd0, bus.rsp_lane}, 64'd1);
            bus.rsp_ready = 1'b1;
         end
      join
      check("t3_all_accepted", 64'(acc_cnt), 64'd6);
      wait_drain();

      // 4: same-address dual write conflict and saturation
      send(1'b1, 2'b11, {8'd9, 8'd9}, 64'h0000_0002_0000_0001, 64'd0);
      check("t4_w_en", {62'd0, rf_w_en}, 64'd2);
      check("t4_conflict1", {56'd0, conflict_cnt}, 64'd1);
      send(1'b0, 2'b01, {8'd0, 8'd9}, 64'd0, 64'h0000_0000_0000_0002);
      send(1'b0, 2'b11, {8'd9, 8'd9}, 64'd0, 64'h0000_0002_0000_0002);
      wait_drain();
      for (int i = 0; i < 256; i++)
         send(1'b1, 2'b11, {8'd9, 8'd9}, 64'h0000_0002_0000_0001, 64'd0);
      check("t4_saturate", {56'd0, conflict_cnt}, 64'd255);

      // 5: reset with two reads in flight and one response queued
      bus.rsp_ready = 1'b0;
      send(1'b0, 2'b01, 16'h0005, 64'd0, 64'h0000_0000_A5A5_A5A5);
      send(1'b0, 2'b01, 16'h0005, 64'd0, 64'h0000_0000_A5A5_A5A5);
      send(1'b0, 2'b11, {8'd7, 8'd3}, 64'd0, 64'h2222_2222_1111_1111);
      check("t5_queued", {63'd0, bus.rsp_valid}, 64'd1);
      check("t5_inflight", {62'd0, rf_r_en}, 64'd3);
      reset = 1'b1;
      tick();
      exp_q.delete();
      check("t5_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
      check("t5_rf_en", {60'd0, rf_w_en, rf_r_en}, 64'd0);
      check("t5_rsp_data", {bus.rsp_key[61:0], bus.rsp_lane}, 64'd0);
      check("t5_conflict_clr", {56'd0, conflict_cnt}, 64'd0);
      check("t5_ready_low", {63'd0, bus.cmd_ready}, 64'd0);
      reset = 1'b0;
      tick();
      check("t5_ready_up", {63'd0, bus.cmd_ready}, 64'd1);
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("t5_no_late_rsp", {63'd0, bus.rsp_valid}, 64'd0);
      end

      // 6: lane_en = 00 read is accepted and dropped
      send(1'b0, 2'b00, 16'h0005, 64'd0, 64'd0);
      check("t6_no_r_en", {62'd0, rf_r_en}, 64'd0);
      check("t6_ready", {63'd0, bus.cmd_ready}, 64'd1);
      repeat (3) tick();
      check("t6_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
`ifdef KEY_REQ_STATS_EN
      check("t6_rd_cnt_zero", {48'd0, rd_cmd_cnt}, 64'd0);
      send(1'b0, 2'b01, 16'h0005, 64'd0, 64'h0000_0000_A5A5_A5A5);
      wait_drain();
      check("t6_rd_cnt_one", {48'd0, rd_cmd_cnt}, 64'd1);
      check("t6_wr_cnt_zero", {48'd0, wr_cmd_cnt}, 64'd0);
`endif
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
